// File: rtl/hadamard4_frame_collector_pkg.sv
// rtl/hadamard4_frame_collector_pkg.sv - shared Hadamard coefficient and frame types
package hadamard_pkg;
   localparam int COEF_W = 12;
   localparam int IN_W   = 9;
   localparam int NPT    = 4;

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef coef_t [NPT-1:0]          frame_t;
endpackage

// File: rtl/hadamard4_frame_collector_if.sv
// rtl/hadamard4_frame_collector_if.sv - coefficient input and frame handshake bundle
interface hadamard4_frame_collector_if;
   import hadamard_pkg::*;

   logic       start;
   coef_t      y_in;
   logic       frm_ready;
   logic       frm_valid;
   coef_t      y0_o;
   coef_t      y1_o;
   coef_t      y2_o;
   coef_t      y3_o;
   logic [1:0] fill;
   logic       overflow;

   modport master (
      input  start, y_in, frm_ready,
      output frm_valid, y0_o, y1_o, y2_o, y3_o, fill, overflow
   );

   modport slave (
      output start, y_in, frm_ready,
      input  frm_valid, y0_o, y1_o, y2_o, y3_o, fill, overflow
   );
endinterface

// File: rtl/hadamard4_frame_collector_frame_fifo2.sv
// rtl/hadamard4_frame_collector_frame_fifo2.sv - two-entry frame FIFO, drops pushes when full
module frame_fifo2 #(
   parameter int W = 48
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic [1:0]   o_fill,
   output logic         o_full
);
   logic [W-1:0] r_mem0;
   logic [W-1:0] r_mem1;
   logic [1:0]   r_fill;
   logic         w_pop;

   assign w_pop  = i_pop && (r_fill != 2'd0);
   assign o_full = (r_fill == 2'd2);
   assign o_head = r_mem0;
   assign o_fill = r_fill;

   // r_mem0 is always the head; a push while full and not popping is simply ignored.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mem0 <= '0;
         r_mem1 <= '0;
         r_fill <= 2'd0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_fill == 2'd0) begin
                  r_mem0 <= i_din;
                  r_fill <= 2'd1;
               end else if (r_fill == 2'd1) begin
                  r_mem1 <= i_din;
                  r_fill <= 2'd2;
               end
            end
            2'b01: begin
               r_mem0 <= r_mem1;
               r_fill <= r_fill - 2'd1;
            end
            2'b11: begin
               if (r_fill == 2'd1) begin
                  r_mem0 <= i_din;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_din;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/hadamard4_frame_collector.sv
// rtl/hadamard4_frame_collector.sv - skips pipeline fill, packs 4 coefficients per frame, buffers frames
module hadamard4_frame_collector
   import hadamard_pkg::*;
#(
   parameter int LATENCY     = 3,
   parameter int SCALE_SHIFT = 0
) (
   input logic                         clk,
   input logic                         rst_n,
   hadamard4_frame_collector_if.master bus
);
   localparam int SKIP_W = $clog2(LATENCY + 1);

   logic [SKIP_W-1:0] r_skip;
   logic [1:0]        r_idx;
   coef_t             r_slot [0:2];
   logic              r_overflow;

   logic   w_capture;
   logic   w_push;
   logic   w_full;
   logic   w_drop;
   coef_t  w_scaled;
   frame_t w_frame;
   frame_t w_head;
   logic [1:0] w_fill;

   assign w_capture = bus.start && (r_skip == SKIP_W'(LATENCY));
   assign w_push    = w_capture && (r_idx == 2'd3);
   assign w_scaled  = bus.y_in >>> SCALE_SHIFT;
   // Full implies frm_valid, so frm_ready alone decides whether a slot frees up this edge.
   assign w_drop    = w_push && w_full && !bus.frm_ready;

   always_comb begin
      w_frame    = '0;
      w_frame[0] = r_slot[0];
      w_frame[1] = r_slot[1];
      w_frame[2] = r_slot[2];
      w_frame[3] = w_scaled;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_skip     <= '0;
         r_idx      <= 2'd0;
         r_slot[0]  <= '0;
         r_slot[1]  <= '0;
         r_slot[2]  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow | w_drop;
         if (!bus.start) begin
            r_skip <= '0;
            r_idx  <= 2'd0;
         end else if (!w_capture) begin
            r_skip <= r_skip + SKIP_W'(1);
         end else begin
            if (r_idx != 2'd3) r_slot[r_idx] <= w_scaled;
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   frame_fifo2 #(.W(NPT * COEF_W)) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_din   (w_frame),
      .i_pop   (bus.frm_ready),
      .o_head  (w_head),
      .o_fill  (w_fill),
      .o_full  (w_full)
   );

   assign bus.frm_valid = (w_fill != 2'd0);
   assign bus.fill      = w_fill;
   assign bus.overflow  = r_overflow;
   assign bus.y0_o      = w_head[0];
   assign bus.y1_o      = w_head[1];
   assign bus.y2_o      = w_head[2];
   assign bus.y3_o      = w_head[3];
endmodule

// File: tb/tb_hadamard4_frame_collector.sv
// tb/tb_hadamard4_frame_collector.sv - directed self-checking bench for hadamard4_frame_collector
module tb_hadamard4_frame_collector;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   hadamard4_frame_collector_if if0 ();
   hadamard4_frame_collector_if if2 ();

   hadamard4_frame_collector u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.master)
   );

   hadamard4_frame_collector #(.LATENCY(3), .SCALE_SHIFT(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_frame0(input string tag, input int a, input int b, input int c, input int d);
      check({tag, ".y0"}, int'(if0.y0_o), a);
      check({tag, ".y1"}, int'(if0.y1_o), b);
      check({tag, ".y2"}, int'(if0.y2_o), c);
      check({tag, ".y3"}, int'(if0.y3_o), d);
   endtask

   task automatic feed0(input int v);
      if0.y_in = 12'(v);
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      if0.start = 1'b0; if0.y_in = '0; if0.frm_ready = 1'b0;
      if2.start = 1'b0; if2.y_in = '0; if2.frm_ready = 1'b0;
      step();
      step();
      check("rst.valid", int'(if0.frm_valid), 0);
      check("rst.fill", int'(if0.fill), 0);
      check("rst.ovf", int'(if0.overflow), 0);
      check_frame0("rst", 0, 0, 0, 0);
      rst_n = 1'b1;

      // Basic frame on both instances, the second one scaled by 1/4.
      if0.start = 1'b1; if2.start = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         case (e)
            4: begin if0.y_in = 12'(10);  if2.y_in = 12'(16); end
            5: begin if0.y_in = 12'(-2);  if2.y_in = 12'(-5); end
            6: begin if0.y_in = 12'(-4);  if2.y_in = 12'(7);  end
            7: begin if0.y_in = 12'(0);   if2.y_in = 12'(-1); end
            default: begin if0.y_in = 12'(77); if2.y_in = 12'(77); end
         endcase
         step();
         if (e == 6) check("f1.early_valid", int'(if0.frm_valid), 0);
      end
      check("f1.valid", int'(if0.frm_valid), 1);
      check("f1.fill", int'(if0.fill), 1);
      check_frame0("f1", 10, -2, -4, 0);
      check("sc.y0", int'(if2.y0_o), 4);
      check("sc.y1", int'(if2.y1_o), -2);
      check("sc.y2", int'(if2.y2_o), 1);
      check("sc.y3", int'(if2.y3_o), -1);
      if2.start = 1'b0;

      // F2 buffers, F3 overflows with frm_ready held low.
      feed0(20); feed0(21); feed0(22);
      check("f2.partial_fill", int'(if0.fill), 1);
      feed0(23);
      check("f2.fill", int'(if0.fill), 2);
      check("f2.ovf", int'(if0.overflow), 0);
      feed0(30); feed0(31); feed0(32); feed0(33);
      check("f3.fill", int'(if0.fill), 2);
      check("f3.ovf", int'(if0.overflow), 1);
      check_frame0("f3.head", 10, -2, -4, 0);
      if0.start = 1'b0;
      if0.frm_ready = 1'b1;
      step();
      check("pop1.fill", int'(if0.fill), 1);
      check_frame0("pop1", 20, 21, 22, 23);
      step();
      check("pop2.valid", int'(if0.frm_valid), 0);
      check("pop2.fill", int'(if0.fill), 0);
      check("pop2.ovf_sticky", int'(if0.overflow), 1);
      if0.frm_ready = 1'b0;

      // Pop on the same edge a frame completes at fill=2.
      rst_n = 1'b0;
      step();
      check("rst2.ovf", int'(if0.overflow), 0);
      rst_n = 1'b1;
      if0.start = 1'b1;
      feed0(0); feed0(0); feed0(0);
      feed0(1); feed0(2); feed0(3); feed0(4);
      feed0(5); feed0(6); feed0(7); feed0(8);
      check("pp.pre_fill", int'(if0.fill), 2);
      feed0(9); feed0(10); feed0(11);
      if0.frm_ready = 1'b1;
      feed0(12);
      if0.frm_ready = 1'b0;
      check("pp.fill", int'(if0.fill), 2);
      check("pp.ovf", int'(if0.overflow), 0);
      check_frame0("pp.head", 5, 6, 7, 8);
      if0.frm_ready = 1'b1;
      if0.start = 1'b0;
      step();
      check_frame0("pp.tail", 9, 10, 11, 12);
      if0.frm_ready = 1'b0;

      // start drops mid-frame: partial frame discarded, full skip required again.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      if0.start = 1'b1;
      feed0(0); feed0(0); feed0(0);
      feed0(40); feed0(41); feed0(42); feed0(43);
      feed0(50); feed0(51);
      if0.start = 1'b0;
      feed0(52);
      check("sd.fill", int'(if0.fill), 1);
      check_frame0("sd.head", 40, 41, 42, 43);
      if0.start = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         feed0((e >= 4) ? (56 + e) : 99);
         if (e == 6) check("sd.early_fill", int'(if0.fill), 1);
      end
      check("sd.fill2", int'(if0.fill), 2);
      check_frame0("sd.head2", 40, 41, 42, 43);
      if0.frm_ready = 1'b1;
      step();
      if0.frm_ready = 1'b0;
      check_frame0("sd.new", 60, 61, 62, 63);

      // Reset mid-frame with fill=1, start held high through reset.
      feed0(70); feed0(71);
      check("mr.pre_fill", int'(if0.fill), 1);
      rst_n = 1'b0;
      step();
      check("mr.valid", int'(if0.frm_valid), 0);
      check("mr.fill", int'(if0.fill), 0);
      check("mr.ovf", int'(if0.overflow), 0);
      check_frame0("mr", 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         feed0((e >= 4) ? (-e) : 5);
         if (e == 6) check("mr.early_fill", int'(if0.fill), 0);
      end
      check("mr.fill_after", int'(if0.fill), 1);
      check_frame0("mr.frame", -4, -5, -6, -7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
